// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and pipe_hazard_ctrl.
// The datapath (master) supplies the hazard sources and consumes the
// register enables, flushes, timeout pulse and performance counters.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ack;

  logic        pc_we;
  logic        ifid_we;
  logic        idex_we;
  logic        exmem_we;
  logic        memwb_we;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        memwb_flush;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ack,
    input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ack,
    output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Resolves memory waits (with timeout), taken-branch redirects and
// load-use hazards, in that priority order. Enables/flushes are
// combinational; state, timer and the timeout pulse are registered.
// Optional macro PERF_CNT_EN adds saturating stall/flush counters;
// without it stall_cycles and flush_events are tied to zero.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input logic            clk,
  input logic            rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic          timeout_q;
  logic          timeout_next;
  logic          load_use;
  logic          resolve;
  logic          branch_applied;
  // Bit order: {pc, ifid, idex, exmem, memwb}
  logic [4:0]    we;
  // Bit order: {ifid, idex, exmem, memwb}
  logic [3:0]    fl;

  // A load writing a nonzero register that the ID instruction reads
  assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  // Next-state logic and enable/flush pattern selection
  always_comb begin
    we             = 5'b11111;
    fl             = 4'b0000;
    next_state     = state;
    timer_next     = timer;
    timeout_next   = 1'b0;
    resolve        = 1'b0;
    branch_applied = 1'b0;

    case (state)
      RUN: begin
        if (bus.mem_req && !bus.mem_ack) begin
          we         = 5'b00000;
          next_state = MEM_WAIT;
          timer_next = TW'(1);
        end else begin
          resolve = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ack) begin
          resolve    = 1'b1;
          next_state = RUN;
          timer_next = '0;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          we           = 5'b00010;
          fl           = 4'b0010;
          timeout_next = 1'b1;
          next_state   = RUN;
          timer_next   = '0;
        end else begin
          we         = 5'b00000;
          timer_next = timer + TW'(1);
        end
      end
      default: begin
        next_state = RUN;
        timer_next = '0;
      end
    endcase

    // A taken branch squashes the ID instruction, so load-use is moot
    if (resolve) begin
      if (bus.ex_branch_taken) begin
        fl             = 4'b1100;
        branch_applied = 1'b1;
      end else if (load_use) begin
        we = 5'b00111;
        fl = 4'b0100;
      end
    end

    if (rst) begin
      we             = 5'b00000;
      fl             = 4'b0000;
      branch_applied = 1'b0;
    end
  end

  // State, timer and one-cycle timeout pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      timer     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= next_state;
      timer     <= timer_next;
      timeout_q <= timeout_next;
    end
  end

  assign bus.pc_we       = we[4];
  assign bus.ifid_we     = we[3];
  assign bus.idex_we     = we[2];
  assign bus.exmem_we    = we[1];
  assign bus.memwb_we    = we[0];
  assign bus.ifid_flush  = fl[3];
  assign bus.idex_flush  = fl[2];
  assign bus.exmem_flush = fl[1];
  assign bus.memwb_flush = fl[0];
  assign bus.mem_timeout = timeout_q;

`ifdef PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Saturating counters of stalled-PC cycles and applied branch flushes
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!we[4] && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (branch_applied && (flush_q != 32'hFFFF_FFFF)) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_events = flush_q;
`else
  logic perf_unused;
  assign perf_unused      = branch_applied;
  assign bus.stall_cycles = 32'd0;
  assign bus.flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard testbench for pipe_hazard_ctrl (TIMEOUT=4).
// Stimulus pushes hand-computed expectations; a monitor on the falling
// edge pops and compares them against the DUT outputs.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [4:0] WE_NORM = 5'b11111;
  localparam logic [4:0] WE_ZERO = 5'b00000;
  localparam logic [4:0] WE_LU   = 5'b00111;
  localparam logic [4:0] WE_TO   = 5'b00010;
  localparam logic [3:0] FL_NONE = 4'b0000;
  localparam logic [3:0] FL_LU   = 4'b0100;
  localparam logic [3:0] FL_BR   = 4'b1100;
  localparam logic [3:0] FL_TO   = 4'b0010;

  typedef struct {
    string       name;
    logic [4:0]  we;
    logic [3:0]  fl;
    logic        to;
    logic [31:0] sc;
    logic [31:0] fe;
  } expect_t;

  logic clk;
  logic rst;
  pipe_hazard_ctrl_if bus ();

  expect_t     sb[$];
  int          n_compared;
  int          n_mismatched;
  logic [31:0] model_stall;
  logic [31:0] model_flush;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .TW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs and queue the expected response
  task automatic applyStimulus(input string name, input bit r,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input bit u1, input bit u2,
                               input logic [4:0] exrd, input bit exmr,
                               input bit br, input bit req, input bit ack,
                               input logic [4:0] ewe, input logic [3:0] efl,
                               input bit eto);
    expect_t e;
    @(posedge clk);
    #1;
    rst                 = r;
    bus.id_rs1          = rs1;
    bus.id_rs2          = rs2;
    bus.id_use_rs1      = u1;
    bus.id_use_rs2      = u2;
    bus.ex_rd           = exrd;
    bus.ex_mem_read     = exmr;
    bus.ex_branch_taken = br;
    bus.mem_req         = req;
    bus.mem_ack         = ack;
    e.name = name;
    e.we   = ewe;
    e.fl   = efl;
    e.to   = eto;
    e.sc   = PERF ? model_stall : 32'd0;
    e.fe   = PERF ? model_flush : 32'd0;
    sb.push_back(e);
    if (r) begin
      model_stall = 32'd0;
      model_flush = 32'd0;
    end else begin
      if (!ewe[4]) model_stall = model_stall + 32'd1;
      if (efl == FL_BR) model_flush = model_flush + 32'd1;
    end
  endtask

  // Compare one expectation against the DUT's present outputs
  task automatic checkOutput(input expect_t e);
    logic [4:0] got_we;
    logic [3:0] got_fl;
    got_we = {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we};
    got_fl = {bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};
    n_compared++;
    if (got_we !== e.we) begin
      n_mismatched++;
      $display("[TB] FAIL %s.we got %b expected %b", e.name, got_we, e.we);
    end
    n_compared++;
    if (got_fl !== e.fl) begin
      n_mismatched++;
      $display("[TB] FAIL %s.flush got %b expected %b", e.name, got_fl, e.fl);
    end
    n_compared++;
    if (bus.mem_timeout !== e.to) begin
      n_mismatched++;
      $display("[TB] FAIL %s.mem_timeout got %b expected %b", e.name, bus.mem_timeout, e.to);
    end
    n_compared++;
    if (bus.stall_cycles !== e.sc) begin
      n_mismatched++;
      $display("[TB] FAIL %s.stall_cycles got %0d expected %0d", e.name, bus.stall_cycles, e.sc);
    end
    n_compared++;
    if (bus.flush_events !== e.fe) begin
      n_mismatched++;
      $display("[TB] FAIL %s.flush_events got %0d expected %0d", e.name, bus.flush_events, e.fe);
    end
  endtask

  // Monitor: on each falling edge, check any pending expectation
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  // Directed stimulus sequence
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    model_stall  = 32'd0;
    model_flush  = 32'd0;
    rst                 = 1'b1;
    bus.id_rs1          = 5'd0;
    bus.id_rs2          = 5'd0;
    bus.id_use_rs1      = 1'b0;
    bus.id_use_rs2      = 1'b0;
    bus.ex_rd           = 5'd0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.mem_req         = 1'b0;
    bus.mem_ack         = 1'b0;
    repeat (2) @(posedge clk);

    //            name           rst rs1 rs2 u1 u2 exrd mr br rq ak  we       flush    to
    applyStimulus("reset",        1, 0,  0,  0, 0, 0,   0, 0, 0, 0, WE_ZERO, FL_NONE, 0);
    applyStimulus("idle",         0, 0,  0,  0, 0, 0,   0, 0, 0, 0, WE_NORM, FL_NONE, 0);
    applyStimulus("lu_rs1",       0, 5,  0,  1, 0, 5,   1, 0, 0, 0, WE_LU,   FL_LU,   0);
    applyStimulus("lu_rs1_unused",0, 5,  0,  0, 0, 5,   1, 0, 0, 0, WE_NORM, FL_NONE, 0);
    applyStimulus("lu_rs2",       0, 1,  9,  1, 1, 9,   1, 0, 0, 0, WE_LU,   FL_LU,   0);
    applyStimulus("lu_not_load",  0, 5,  0,  1, 0, 5,   0, 0, 0, 0, WE_NORM, FL_NONE, 0);
    applyStimulus("lu_removed",   0, 5,  0,  1, 0, 6,   1, 0, 0, 0, WE_NORM, FL_NONE, 0);
    applyStimulus("x0_load",      0, 0,  0,  1, 0, 0,   1, 0, 0, 0, WE_NORM, FL_NONE, 0);
    applyStimulus("br_plus_lu",   0, 5,  0,  1, 0, 5,   1, 1, 0, 0, WE_NORM, FL_BR,   0);
    applyStimulus("req_ack_same", 0, 0,  0,  0, 0, 0,   0, 0, 1, 1, WE_NORM, FL_NONE, 0);
    applyStimulus("req_ack_lu",   0, 3,  0,  1, 0, 3,   1, 0, 1, 1, WE_LU,   FL_LU,   0);
    // Memory wait acked on the final timer cycle (timer==TIMEOUT-1)
    applyStimulus("mw_run",       0, 0,  0,  0, 0, 0,   0, 0, 1, 0, WE_ZERO, FL_NONE, 0);
    applyStimulus("mw_t1",        0, 0,  0,  0, 0, 0,   0, 0, 1, 0, WE_ZERO, FL_NONE, 0);
    applyStimulus("mw_t2",        0, 0,  0,  0, 0, 0,   0, 0, 1, 0, WE_ZERO, FL_NONE, 0);
    applyStimulus("mw_ack",       0, 0,  0,  0, 0, 0,   0, 0, 1, 1, WE_NORM, FL_NONE, 0);
    applyStimulus("mw_after",     0, 0,  0,  0, 0, 0,   0, 0, 0, 0, WE_NORM, FL_NONE, 0);
    // Branch applied in the MEM_WAIT ack cycle
    applyStimulus("mwb_run",      0, 0,  0,  0, 0, 0,   0, 1, 1, 0, WE_ZERO, FL_NONE, 0);
    applyStimulus("mwb_ack_br",   0, 0,  0,  0, 0, 0,   0, 1, 1, 1, WE_NORM, FL_BR,   0);
    // Load-use resolved in the MEM_WAIT ack cycle
    applyStimulus("mwl_run",      0, 7,  0,  1, 0, 7,   1, 0, 1, 0, WE_ZERO, FL_NONE, 0);
    applyStimulus("mwl_ack_lu",   0, 7,  0,  1, 0, 7,   1, 0, 1, 1, WE_LU,   FL_LU,   0);
    // Timeout: ack never arrives
    applyStimulus("to_run",       0, 0,  0,  0, 0, 0,   0, 0, 1, 0, WE_ZERO, FL_NONE, 0);
    applyStimulus("to_t1",        0, 0,  0,  0, 0, 0,   0, 0, 1, 0, WE_ZERO, FL_NONE, 0);
    applyStimulus("to_t2",        0, 0,  0,  0, 0, 0,   0, 0, 1, 0, WE_ZERO, FL_NONE, 0);
    applyStimulus("to_abandon",   0, 0,  0,  0, 0, 0,   0, 0, 1, 0, WE_TO,   FL_TO,   0);
    applyStimulus("to_pulse",     0, 0,  0,  0, 0, 0,   0, 0, 0, 0, WE_NORM, FL_NONE, 1);
    applyStimulus("to_pulse_end", 0, 0,  0,  0, 0, 0,   0, 0, 0, 0, WE_NORM, FL_NONE, 0);
    // Reset landing on the cycle that would otherwise time out
    applyStimulus("rw_run",       0, 0,  0,  0, 0, 0,   0, 0, 1, 0, WE_ZERO, FL_NONE, 0);
    applyStimulus("rw_t1",        0, 0,  0,  0, 0, 0,   0, 0, 1, 0, WE_ZERO, FL_NONE, 0);
    applyStimulus("rw_t2",        0, 0,  0,  0, 0, 0,   0, 0, 1, 0, WE_ZERO, FL_NONE, 0);
    applyStimulus("rw_reset",     1, 5,  0,  1, 0, 5,   1, 1, 1, 0, WE_ZERO, FL_NONE, 0);
    applyStimulus("rw_release",   0, 0,  0,  0, 0, 0,   0, 0, 0, 0, WE_NORM, FL_NONE, 0);
    applyStimulus("rw_run_again", 0, 0,  0,  0, 0, 0,   0, 1, 0, 0, WE_NORM, FL_BR,   0);
    applyStimulus("final",        0, 0,  0,  0, 0, 0,   0, 0, 0, 0, WE_NORM, FL_NONE, 0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    n_compared++;
    if (sb.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL drain pending %0d expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Global time limit
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] time limit");
  end

endmodule
